crc_stream_engine: RTL
======================

CRC_STREAM_ENGINE -- requirements
Module: crc_stream_engine

Interface
REQ-001 Parameter CRC_W, default 16: CRC register width; legal range 8..32.
REQ-002 Parameter DATA_W, default 8: input beat width; a multiple of 8, range 8..64.
REQ-003 Parameter POLY [CRC_W-1:0], default 16'h1021: generator polynomial in normal form, implicit top bit omitted.
REQ-004 Parameter INIT [CRC_W-1:0], default 16'hFFFF: register value at reset, on clear, and at frame start.
REQ-005 Parameter XOR_OUT [CRC_W-1:0], default 0: value XORed onto the result.
REQ-006 Parameters REFIN and REFOUT, default 0: 1 reflects each input byte, or the output word, respectively.
REQ-007 Parameter RESIDUE [CRC_W-1:0], default 0: expected register value after a frame that carries its own CRC.
REQ-008 Port clk, input, 1: single clock; all logic is rising-edge.
REQ-009 Port reset_n, input, 1: reset, asynchronous assert and active-low.
REQ-010 Port clear, input, 1: synchronous abort of the current frame.
REQ-011 Port in_valid / in_ready, input / output, 1 each: input handshake.
REQ-012 Port in_data, input, DATA_W: beat data; byte 0 = in_data[7:0] is processed first.
REQ-013 Port in_keep, input, DATA_W/8: byte enables; honoured only when in_last=1.
REQ-014 Port in_last, input, 1: marks the final beat of a frame.
REQ-015 Port out_valid / out_ready, output / input, 1 each: result handshake.
REQ-016 Port out_crc, output, CRC_W: final CRC with REFOUT and XOR_OUT applied.
REQ-017 Port out_match, output, 1: high when the raw register equals RESIDUE.

Function
REQ-018 A beat is accepted when in_valid & in_ready, and only then.
REQ-019 in_ready SHALL equal !out_valid | out_ready: pass-through, with no bubble under back-pressure release.
REQ-020 Non-last beat: the register SHALL absorb all DATA_W/8 bytes in one cycle, in byte order 0 upward.
REQ-021 Last beat: the register SHALL absorb only bytes whose in_keep bit is set.
- in_keep SHALL be contiguous from bit 0.
- in_keep = 0 on a last beat SHALL be treated as all-ones.
REQ-022 Within a byte, bit 7 is fed first when REFIN=0; bit 0 is fed first when REFIN=1.
REQ-023 out_valid SHALL rise the cycle after the last beat is accepted; latency is 1 cycle.
REQ-024 out_crc and out_match SHALL be registered and held stable while out_valid & !out_ready.
REQ-025 The register SHALL return to INIT in the cycle following last-beat acceptance, so the next frame starts clean.
REQ-026 When out_valid & out_ready and a new beat is accepted in the same cycle, the new beat SHALL be computed from INIT.
- out_valid SHALL stay high only if that beat is itself last.
REQ-027 clear SHALL have priority over all activity.
- Register <= INIT and out_valid <= 0 next cycle.
- A beat accepted in the clear cycle SHALL be discarded.
REQ-028 State machine:
- IDLE, the register at INIT: first beat accepted -> ACCUM, or -> DONE if in_last.
- ACCUM: last beat accepted -> DONE.
- DONE, out_valid=1: out_ready with no new beat -> IDLE; out_ready with a new beat -> ACCUM, or DONE if in_last.
REQ-029 With in_valid low, the register and state SHALL hold.

Reset
REQ-030 While reset_n=0, and immediately on its assertion: register=INIT, state=IDLE, out_valid=0, out_crc=0, out_match=0.
REQ-031 in_ready SHALL be 1 out of reset; reset mid-frame discards that frame without emitting a result.

Structure
REQ-032 Package crc_pkg SHALL hold the byte-reflect and word-reflect functions and the state enumeration.
REQ-033 Sub-module crc_byte_step SHALL compute one byte update combinationally.
- Parameters CRC_W, POLY, REFIN.
- Instantiated DATA_W/8 times in a chain.
- Each stage output is muxed by its in_keep bit.

Verification
REQ-034 Defaults, single frame of the 9 bytes "123456789", DATA_W=8 -> out_crc=16'h29B1 one cycle after the last beat.
REQ-035 INIT=0 -> 16'h31C3.
REQ-036 REFIN=REFOUT=1, INIT=0 -> 16'h2189.
REQ-037 CRC_W=32, POLY=32'h04C11DB7, INIT=XOR_OUT=32'hFFFFFFFF, REFIN=REFOUT=1, DATA_W=32, "123456789" as 3 beats with last keep=4'b0001 -> 32'hCBF43926.
REQ-038 Defaults, "123456789" followed by bytes 8'h29, 8'hB1 -> out_match=1; flip one data bit -> out_match=0.
REQ-039 Back-to-back frames, out_ready held low for 5 cycles then pulsed while a new last beat is presented.
- out_crc stays stable while held.
- Second result is correct, with no lost beats.
- Assert clear mid-frame, then send a full frame -> result matches REQ-034.

Source files
------------

// File: rtl/crc_pkg.sv
// rtl/crc_pkg.sv - shared state encoding and bit-reflection helpers for the CRC stream engine
package crc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic [7:0] reflect_byte(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  // Reflects the low w bits of v; bits at and above w come back as zero.
  function automatic logic [31:0] reflect_word(input logic [31:0] v, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < w) r[i] = v[w-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/crc_byte_step.sv
// rtl/crc_byte_step.sv - combinational one-byte CRC update, MSB-first shift form
module crc_byte_step
  import crc_pkg::*;
#(
  parameter int              CRC_W = 16,
  parameter logic [CRC_W-1:0] POLY = CRC_W'(16'h1021),
  parameter bit              REFIN = 1'b0
) (
  input  logic [CRC_W-1:0] crc_i,
  input  logic [7:0]       byte_i,
  output logic [CRC_W-1:0] crc_o
);

  logic [7:0]       b_s;
  logic [CRC_W-1:0] c_s;
  logic             fb_s;

  // Reflecting the input byte lets one shift direction serve both bit orders.
  always_comb begin
    b_s  = REFIN ? reflect_byte(byte_i) : byte_i;
    c_s  = crc_i;
    fb_s = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      fb_s = c_s[CRC_W-1] ^ b_s[i];
      c_s  = {c_s[CRC_W-2:0], 1'b0} ^ (fb_s ? POLY : '0);
    end
    crc_o = c_s;
  end

endmodule

// File: rtl/crc_stream_engine.sv
// rtl/crc_stream_engine.sv - streaming CRC engine: multi-byte beats in, one registered CRC per frame out
module crc_stream_engine
  import crc_pkg::*;
#(
  parameter int               CRC_W   = 16,
  parameter int               DATA_W  = 8,
  parameter logic [CRC_W-1:0] POLY    = CRC_W'(16'h1021),
  parameter logic [CRC_W-1:0] INIT    = CRC_W'(16'hFFFF),
  parameter logic [CRC_W-1:0] XOR_OUT = '0,
  parameter bit               REFIN   = 1'b0,
  parameter bit               REFOUT  = 1'b0,
  parameter logic [CRC_W-1:0] RESIDUE = '0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clear,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [DATA_W/8-1:0] in_keep,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CRC_W-1:0]    out_crc,
  output logic                out_match
);

  localparam int NB = DATA_W / 8;

  state_e           state_q, state_d;
  logic [CRC_W-1:0] crc_q, crc_d;
  logic [CRC_W-1:0] out_crc_q, out_crc_d;
  logic             out_match_q, out_match_d;
  logic             accept;
  logic [NB-1:0]    keep_eff;
  logic [CRC_W-1:0] chain_out;
  logic [CRC_W-1:0] crc_fin;

  assign out_valid = (state_q == ST_DONE);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign out_crc   = out_crc_q;
  assign out_match = out_match_q;

  // Keep is only meaningful on the last beat, where all-zero means a full beat.
  assign keep_eff = (in_last && (in_keep != '0)) ? in_keep : '1;

  // crc_q is INIT whenever a frame starts, so the chain always seeds from it.
  for (genvar k = 0; k < NB; k++) begin : g_stage
    logic [CRC_W-1:0] c_in, c_step, c_out;
    if (k == 0) begin : g_first
      assign c_in = crc_q;
    end else begin : g_next
      assign c_in = g_stage[k-1].c_out;
    end
    crc_byte_step #(
      .CRC_W (CRC_W),
      .POLY  (POLY),
      .REFIN (REFIN)
    ) u_step (
      .crc_i  (c_in),
      .byte_i (in_data[8*k +: 8]),
      .crc_o  (c_step)
    );
    assign c_out = keep_eff[k] ? c_step : c_in;
  end

  assign chain_out = g_stage[NB-1].c_out;
  assign crc_fin   = (REFOUT ? CRC_W'(reflect_word(32'(chain_out), CRC_W)) : chain_out) ^ XOR_OUT;

  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    out_crc_d   = out_crc_q;
    out_match_d = out_match_q;
    if (clear) begin
      state_d = ST_IDLE;
      crc_d   = INIT;
    end else begin
      if (accept) begin
        crc_d = in_last ? INIT : chain_out;
        if (in_last) begin
          out_crc_d   = crc_fin;
          out_match_d = (chain_out == RESIDUE);
        end
      end
      case (state_q)
        ST_IDLE:  if (accept) state_d = in_last ? ST_DONE : ST_ACCUM;
        ST_ACCUM: if (accept && in_last) state_d = ST_DONE;
        ST_DONE: begin
          if (out_ready) begin
            if (accept) state_d = in_last ? ST_DONE : ST_ACCUM;
            else        state_d = ST_IDLE;
          end
        end
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      crc_q       <= INIT;
      out_crc_q   <= '0;
      out_match_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      out_crc_q   <= out_crc_d;
      out_match_q <= out_match_d;
    end
  end

endmodule
